// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU byte bus.
// Captures a CPU request, waits WAIT_CYC cycles, serves it from an internal
// byte RAM and reports completion with a one-cycle ready pulse (err alongside
// for out-of-range or read/write conflicts). A loader port preloads the RAM
// while ld_en holds the CPU off.
module mem_responder #(
    parameter int          DEPTH_W  = 8,
    parameter int          WAIT_CYC = 1,
    parameter logic [7:0]  OOR_DATA = 8'hFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        addr,
    input  logic               read,
    input  logic               write,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic               ready,
    output logic               err,
    output logic               busy,
    input  logic               ld_en,
    input  logic               ld_we,
    input  logic [DEPTH_W-1:0] ld_addr,
    input  logic [7:0]         ld_wdata,
    output logic [7:0]         ld_rdata
);

    localparam int DEPTH = 1 << DEPTH_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Captured request: once taken, these values rule the access.
    logic [15:0] addr_q, addr_d;
    logic [7:0]  din_q, din_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [3:0]  cnt_q, cnt_d;

    // Registered outputs.
    logic [7:0]  dout_q, dout_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [7:0]  ld_rdata_q, ld_rdata_d;

    // Byte RAM with a single shared write port (CPU commit or loader).
    logic [7:0]         mem [DEPTH];
    logic               mem_we;
    logic [DEPTH_W-1:0] mem_waddr;
    logic [7:0]         mem_wdata;

    logic               in_range;
    logic               cpu_req;
    logic               wait_done;
    logic               addr_moved;

    // Upper address bits above the RAM must be zero for an in-range access.
    generate
        if (DEPTH_W < 16) begin : g_range
            assign in_range = (addr_q[15:DEPTH_W] == '0);
        end else begin : g_full
            assign in_range = 1'b1;
        end
    endgenerate

    assign cpu_req    = !ld_en && (read || write);
    assign wait_done  = (({1'b0, cnt_q} + 5'd1) == 5'(WAIT_CYC));
    assign addr_moved = (addr != addr_q);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> WAIT -> RESP -> HOLD -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    state_d = (WAIT_CYC == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_done) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                // A level-held strobe on the same address must not re-trigger.
                if (!(read || write) || addr_moved) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request capture and wait-state counter.
    always_comb begin
        addr_d = addr_q;
        din_d  = din_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 4'd0;
                if (cpu_req) begin
                    addr_d = addr;
                    din_d  = din;
                    rd_d   = read;
                    wr_d   = write;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 4'd1;
            end
            default: begin
                cnt_d = 4'd0;
            end
        endcase
    end

    // Response outputs, RAM write port selection and loader readback.
    always_comb begin
        busy       = (state_q != S_IDLE);
        ready_d    = 1'b0;
        err_d      = 1'b0;
        dout_d     = dout_q;
        mem_we     = ld_en && ld_we;
        mem_waddr  = ld_addr;
        mem_wdata  = ld_wdata;
        ld_rdata_d = mem[ld_addr];
        if (state_q == S_RESP) begin
            ready_d = 1'b1;
            if (rd_q && wr_q) begin
                err_d = 1'b1;
            end else if (!in_range) begin
                err_d = 1'b1;
                if (rd_q) begin
                    dout_d = OOR_DATA;
                end
            end else if (rd_q) begin
                dout_d = mem[addr_q[DEPTH_W-1:0]];
            end else if (wr_q && !rst) begin
                // The completing CPU write wins the port over the loader.
                mem_we    = 1'b1;
                mem_waddr = addr_q[DEPTH_W-1:0];
                mem_wdata = din_q;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= 16'h0000;
            din_q      <= 8'h00;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            cnt_q      <= 4'd0;
            dout_q     <= 8'h00;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            ld_rdata_q <= 8'h00;
        end else begin
            addr_q     <= addr_d;
            din_q      <= din_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            ld_rdata_q <= ld_rdata_d;
        end
    end

    // RAM array: contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign dout     = dout_q;
    assign ready    = ready_q;
    assign err      = err_q;
    assign ld_rdata = ld_rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: fixed vector table, hand-written corner sequences
// and randomized traffic checked against a byte-array reference model.
module tb_mem_responder;

    localparam int DEPTH_W  = 8;
    localparam int WAIT_CYC = 1;
    localparam int DEPTH    = 1 << DEPTH_W;

    logic               clk;
    logic               rst;
    logic [15:0]        addr;
    logic               read;
    logic               write;
    logic [7:0]         din;
    logic [7:0]         dout;
    logic               ready;
    logic               err;
    logic               busy;
    logic               ld_en;
    logic               ld_we;
    logic [DEPTH_W-1:0] ld_addr;
    logic [7:0]         ld_wdata;
    logic [7:0]         ld_rdata;

    int errors = 0;
    int checks = 0;
    int txn    = 0;

    logic [7:0] model_mem [DEPTH];
    logic [7:0] model_dout;

    mem_responder #(
        .DEPTH_W (DEPTH_W),
        .WAIT_CYC(WAIT_CYC),
        .OOR_DATA(8'hFF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .read    (read),
        .write   (write),
        .din     (din),
        .dout    (dout),
        .ready   (ready),
        .err     (err),
        .busy    (busy),
        .ld_en   (ld_en),
        .ld_we   (ld_we),
        .ld_addr (ld_addr),
        .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        bit          r;
        bit          w;
        logic [7:0]  d;
        logic [7:0]  exp_dout;
        bit          exp_err;
    } vec_t;

    vec_t vecs [11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: what one complete CPU access should produce.
    task automatic model_apply(input logic [15:0] a, input bit r, input bit w,
                               input logic [7:0] d, output logic [7:0] e_dout,
                               output bit e_err);
        e_err = 1'b0;
        if (r && w) begin
            e_err = 1'b1;
        end else if (int'(a) >= DEPTH) begin
            e_err = 1'b1;
            if (r) model_dout = 8'hFF;
        end else if (r) begin
            model_dout = model_mem[a];
        end else begin
            model_mem[a] = d;
        end
        e_dout = model_dout;
    endtask

    // Wait (bounded) for the ready pulse; k counts edges from the call.
    task automatic wait_ready(output bit got, output int lat, output logic [7:0] o,
                              output bit e);
        got = 1'b0;
        lat = 0;
        o   = 8'h00;
        e   = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            step();
            if (ready) begin
                got = 1'b1;
                lat = k;
                o   = dout;
                e   = err;
            end
        end
    endtask

    // One complete CPU access checked against expected dout/err.
    task automatic cpu_access(input string tag, input logic [15:0] a, input bit r,
                              input bit w, input logic [7:0] d,
                              input logic [7:0] e_dout, input bit e_err);
        bit         got;
        int         lat;
        logic [7:0] o;
        bit         e;
        addr  = a;
        read  = r;
        write = w;
        din   = d;
        wait_ready(got, lat, o, e);
        txn++;
        $display("txn %0d %s addr=%h rd=%0d wr=%0d din=%h -> ready=%0d lat=%0d dout=%h err=%0d",
                 txn, tag, a, r, w, d, got, lat, o, e);
        check({tag, "_ready"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, "_latency"}, 32'(lat), 32'(WAIT_CYC + 2));
            check({tag, "_dout"}, 32'(o), 32'(e_dout));
            check({tag, "_err"}, 32'(e), 32'(e_err));
        end
        read  = 1'b0;
        write = 1'b0;
        step();
        check({tag, "_ready_pulse"}, 32'(ready), 32'd0);
        step();
    endtask

    initial begin
        bit         got;
        int         lat;
        logic [7:0] o;
        bit         e;
        int         extra;
        logic [7:0] e_dout;
        bit         e_err;
        logic [7:0] old;

        rst = 1'b1; addr = '0; read = 0; write = 0; din = '0;
        ld_en = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
        model_dout = 8'h00;

        // Reset
        step(); step();
        check("reset_dout", 32'(dout), 32'h00);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ld_rdata", 32'(ld_rdata), 32'h00);
        rst = 1'b0;
        step();

        // Preload every byte through the loader.
        ld_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            if (i == 8'h00) v = 8'h11;
            if (i == 8'h10) v = 8'h5A;
            model_mem[i] = v;
            ld_we = 1'b1; ld_addr = 8'(i); ld_wdata = v;
            step();
        end
        ld_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ld_addr = 8'($urandom);
            step();
            check("ld_readback", 32'(ld_rdata), 32'(model_mem[ld_addr]));
        end

        // Same-edge write and read of one address returns the old byte.
        old = model_mem[8'h10];
        ld_we = 1'b1; ld_addr = 8'h10; ld_wdata = 8'h3C;
        step();
        check("ld_same_edge_old", 32'(ld_rdata), 32'(old));
        ld_we = 1'b0;
        model_mem[8'h10] = 8'h3C;
        step();
        check("ld_new_data", 32'(ld_rdata), 32'h3C);

        // CPU read while the loader holds the bus: no capture, no ready.
        addr = 16'h0010; read = 1'b1;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ready || busy) extra++;
        end
        check("ld_en_blocks_cpu", 32'(extra), 32'd0);
        read = 1'b0;
        ld_en = 1'b0;
        step();

        // Vector table.
        vecs[0]  = '{16'h0010, 1'b1, 1'b0, 8'h00, 8'h3C, 1'b0};
        vecs[1]  = '{16'h0020, 1'b0, 1'b1, 8'hA5, 8'h3C, 1'b0};
        vecs[2]  = '{16'h0020, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0};
        vecs[3]  = '{16'h0100, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b1};
        vecs[4]  = '{16'h0100, 1'b0, 1'b1, 8'h77, 8'hFF, 1'b1};
        vecs[5]  = '{16'h0000, 1'b1, 1'b0, 8'h00, 8'h11, 1'b0};
        vecs[6]  = '{16'h0020, 1'b1, 1'b1, 8'h00, 8'h11, 1'b1};
        vecs[7]  = '{16'h0020, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0};
        vecs[8]  = '{16'h00FF, 1'b0, 1'b1, 8'hC3, 8'hA5, 1'b0};
        vecs[9]  = '{16'h00FF, 1'b1, 1'b0, 8'h00, 8'hC3, 1'b0};
        vecs[10] = '{16'hFFFF, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b1};
        for (int i = 0; i < 11; i++) begin
            cpu_access("vec", vecs[i].a, vecs[i].r, vecs[i].w, vecs[i].d,
                       vecs[i].exp_dout, vecs[i].exp_err);
            model_apply(vecs[i].a, vecs[i].r, vecs[i].w, vecs[i].d, e_dout, e_err);
        end

        // Held strobe must not re-trigger; moving the address starts a new access.
        addr = 16'h0010; read = 1'b1;
        wait_ready(got, lat, o, e);
        txn++;
        $display("txn %0d hold addr=0010 -> ready=%0d dout=%h", txn, got, o);
        check("hold_first_ready", 32'(got), 32'd1);
        check("hold_first_dout", 32'(o), 32'h3C);
        model_dout = 8'h3C;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ready) extra++;
        end
        check("hold_no_retrigger", 32'(extra), 32'd0);
        check("hold_busy", 32'(busy), 32'd1);
        addr = 16'h0011;
        wait_ready(got, lat, o, e);
        txn++;
        $display("txn %0d hold addr=0011 -> ready=%0d dout=%h", txn, got, o);
        check("hold_new_ready", 32'(got), 32'd1);
        check("hold_new_dout", 32'(o), 32'(model_mem[8'h11]));
        model_dout = model_mem[8'h11];
        read = 1'b0;
        step(); step();

        // ld_en rising mid-access lets that access finish.
        addr = 16'h0020; read = 1'b1;
        step();
        ld_en = 1'b1;
        wait_ready(got, lat, o, e);
        txn++;
        $display("txn %0d ld_en_mid addr=0020 -> ready=%0d dout=%h", txn, got, o);
        check("ld_mid_ready", 32'(got), 32'd1);
        check("ld_mid_dout", 32'(o), 32'hA5);
        model_dout = 8'hA5;
        read = 1'b0;
        step(); step();
        ld_en = 1'b0;

        // Reset during WAIT aborts: no ready, no write.
        old = model_mem[8'h30];
        addr = 16'h0030; write = 1'b1; din = ~old;
        step();
        rst = 1'b1; write = 1'b0;
        step();
        rst = 1'b0;
        model_dout = 8'h00;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            if (ready || busy) extra++;
            step();
        end
        txn++;
        $display("txn %0d abort addr=0030 -> stray=%0d", txn, extra);
        check("abort_no_ready", 32'(extra), 32'd0);
        check("abort_dout_reset", 32'(dout), 32'h00);
        cpu_access("abort_rb", 16'h0030, 1'b1, 1'b0, 8'h00, old, 1'b0);
        model_dout = old;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 150; n++) begin
            logic [15:0] a;
            bit          r;
            bit          w;
            int          kind;
            logic [7:0]  d;
            kind = int'($urandom_range(0, 19));
            r = (kind < 9) || (kind >= 18);
            w = (kind >= 9);
            if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(DEPTH, 16'hFFFF));
            else a = 16'($urandom_range(0, DEPTH - 1));
            d = 8'($urandom);
            model_apply(a, r, w, d, e_dout, e_err);
            cpu_access("rand", a, r, w, d, e_dout, e_err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
